ahb_lite_single_master: RTL and testbench
=========================================

// Module: ahb_lite_single_master
// PURPOSE
// - AHB-Lite initiator; it is the other end of the slave-side response encoding IDLE/NOT_READY/ERROR.
// - Converts a valid/ready command stream into pipelined SINGLE transfers and returns a registered per-transfer response.
// - Sits between an internal requester (test sequencer, DMA engine) and the AHB-Lite interconnect.
// - Handles wait states and two-cycle ERROR, and retries any transfer pipelined behind an error.
// PARAMETERS
// - ADDR_WIDTH  32       HADDR/cmd_addr width
// - DATA_WIDTH  32       HWDATA/HRDATA width (32 only; HSIZE max 3'b010)
// - HPROT_VAL   4'b0011  constant HPROT (non-cacheable, privileged data)
// PORTS
// - HCLK       in   1           clock; all state on rising edge
// - HRESET     in   1           asynchronous, active-high reset
// - cmd_valid  in   1           command offered
// - cmd_ready  out  1           command slot free
// - cmd_write  in   1           1=write, 0=read
// - cmd_addr   in   ADDR_WIDTH  transfer address
// - cmd_size   in   3           HSIZE value
// - cmd_wdata  in   DATA_WIDTH  write data
// - rsp_valid  out  1           one-cycle response pulse; no backpressure
// - rsp_error  out  1           1 = slave returned ERROR
// - rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
// - HADDR      out  ADDR_WIDTH  address phase
// - HTRANS     out  2           IDLE 2'b00 / NONSEQ 2'b10 only
// - HWRITE     out  1           ;  HSIZE out 3 ; HBURST out 3 (fixed 3'b000) ; HPROT out 4
// - HMASTLOCK  out  1           fixed 0
// - HWDATA     out  DATA_WIDTH  data phase write data
// - HREADY     in   1           transfer-complete / ready
// - HRESP      in   1           0=OKAY, 1=ERROR
// - HRDATA     in   DATA_WIDTH  read data
// BEHAVIOUR
// - Two register stages:
//   - A (address phase): a_valid/addr/write/size/wdata.
//   - D (data phase): d_valid/write/wdata.
// - Reset values: all stages empty; HTRANS=IDLE; HADDR/HWRITE/HSIZE/HWDATA=0; rsp_*=0; err_hold=0.
// - cmd_ready = !a_valid | (HREADY & !err_hold & !(d_valid & HRESP)). Combinational. 1 out of reset.
// - Accept at edge (cmd_valid & cmd_ready): load A. NONSEQ is visible the next cycle.
// - HTRANS = (a_valid & !err_hold) ? NONSEQ : IDLE. HADDR/HWRITE/HSIZE are driven from A and held stable while HREADY=0.
// - Edge with HREADY=1 and HTRANS=NONSEQ: A moves to D. A reloads from cmd if accepted, else empties.
// - HWDATA = d_wdata when d_valid & d_write, else 0. Held through wait states.
// - Edge with d_valid & HREADY=1: D completes.
//   - Next cycle: rsp_valid=1, rsp_error=HRESP, rsp_rdata=(read & !HRESP) ? HRDATA : 0.
//   - D empties unless refilled from A in the same edge.
// - Latency with zero wait states: accept edge t -> NONSEQ cycle t+1 -> data phase t+2 -> rsp_valid t+3.
// - Throughput: one transfer per cycle, back-to-back.
// - ERROR, cycle 1 (d_valid & HRESP & !HREADY): set err_hold. Cycle 2 therefore drives HTRANS=IDLE; A is held, not cancelled.
// - ERROR, cycle 2 (HREADY & HRESP): D completes with rsp_error=1; err_hold clears; A is not transferred.
//   - Any pipelined A re-issues as NONSEQ in the following cycle (retry).
// - HRESP=1 together with HREADY=1 on the first cycle (protocol violation): reported as error; no retry handling.
// - HRESP/HRDATA are ignored when D is empty.
// - No alignment or HSIZE checks; these are the requester's responsibility. The values are passed through as-is.
// - HRESET mid-transfer: both stages are dropped immediately; no response is produced for in-flight commands.
// TESTING
// - Zero-wait read: cmd read 0x4000_0010 at t, HRDATA=0xDEAD_BEEF -> NONSEQ t+1, rsp_valid t+3, rdata=0xDEAD_BEEF, error=0.
// - Back-to-back writes to 0x0/0x4/0x8, HREADY=1 -> three consecutive NONSEQ; HWDATA lags HADDR by one cycle; 3 OKAY responses.
// - Write with 3 wait states -> HADDR of the next cmd and HWDATA stable for 3 cycles; cmd_ready=0 during the waits; 1 response.
// - ERROR on read 0x100 with pipelined write 0x104 -> HTRANS=IDLE in ERROR cycle 2; rsp_error=1; then 0x104 re-issued with OKAY.
// - HRESET asserted while a write is in its wait state -> outputs reach reset values asynchronously; no rsp_valid; cmd_ready=1 after release.
// - cmd_valid held low for 5 cycles -> HTRANS=IDLE throughout; stray HRESP=1 produces no response.

Source files
------------

// File: rtl/ahb_lite_single_master_if.sv
// Bundles the command/response stream and the AHB-Lite bus into one interface.
// Ports:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_size/cmd_wdata : command stream.
//   rsp_valid/rsp_error/rsp_rdata                             : per-transfer response.
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA    : AHB-Lite master outputs.
//   HREADY/HRESP/HRDATA                                        : AHB-Lite slave returns.
// The master modport is the initiator's view; the slave modport is the requester
// plus interconnect side that drives commands and bus responses.
interface ahb_lite_single_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_error;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  HREADY, HRESP, HRDATA,
    output cmd_ready, rsp_valid, rsp_error, rsp_rdata,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output HREADY, HRESP, HRDATA,
    input  cmd_ready, rsp_valid, rsp_error, rsp_rdata,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );
endinterface

// File: rtl/ahb_lite_single_master.sv
// AHB-Lite single-transfer initiator. Turns a valid/ready command stream into
// pipelined NONSEQ SINGLE transfers, absorbs wait states and the two-cycle ERROR
// response, and retries any transfer that was pipelined behind an error.
// Ports:
//   HCLK   : clock, all state on the rising edge.
//   HRESET : asynchronous active-high reset; drops both pipeline stages.
//   bus    : master modport carrying the command stream (cmd_*), the registered
//            one-cycle response (rsp_*), and the AHB-Lite signals (H*).
module ahb_lite_single_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  ahb_lite_single_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Address-phase payload held in stage A.
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic [DATA_WIDTH-1:0] wdata;
  } a_payload_t;

  // ERR_HOLD covers the second ERROR cycle, where the pending address must be withdrawn.
  typedef enum logic {ERR_NONE, ERR_HOLD} err_state_t;

  err_state_t            err_state;
  err_state_t            err_state_nxt;
  logic                  err_hold;

  logic                  a_valid;
  a_payload_t            a_q;
  logic                  d_valid;
  logic                  d_write;
  logic [DATA_WIDTH-1:0] d_wdata;

  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  addr_nonseq;
  logic                  addr_done;
  logic                  data_done;
  logic                  accept;

  assign err_hold    = (err_state == ERR_HOLD);
  assign addr_nonseq = a_valid & ~err_hold;
  assign addr_done   = addr_nonseq & bus.HREADY;
  assign data_done   = d_valid & bus.HREADY;

  // A frees up only when its contents leave this very edge; first ERROR cycle blocks it.
  assign bus.cmd_ready = ~a_valid | (bus.HREADY & ~err_hold & ~(d_valid & bus.HRESP));
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  // Error tracking state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_state <= ERR_NONE;
    end else begin
      err_state <= err_state_nxt;
    end
  end

  // Error tracking next state.
  always_comb begin
    err_state_nxt = err_state;
    case (err_state)
      ERR_NONE: if (d_valid && bus.HRESP && !bus.HREADY) err_state_nxt = ERR_HOLD;
      ERR_HOLD: if (bus.HREADY) err_state_nxt = ERR_NONE;
      default:  err_state_nxt = ERR_NONE;
    endcase
  end

  // Stage A: loads on accept, empties when its address phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (accept) begin
      a_valid     <= 1'b1;
      a_q.write   <= bus.cmd_write;
      a_q.addr    <= bus.cmd_addr;
      a_q.size    <= bus.cmd_size;
      a_q.wdata   <= bus.cmd_wdata;
    end else if (addr_done) begin
      a_valid <= 1'b0;
    end
  end

  // Stage D: refilled from A or emptied when the data phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_wdata <= '0;
    end else if (addr_done) begin
      d_valid <= 1'b1;
      d_write <= a_q.write;
      d_wdata <= a_q.wdata;
    end else if (data_done) begin
      d_valid <= 1'b0;
    end
  end

  // Registered response, one pulse per completed data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= data_done;
      rsp_error_q <= data_done & bus.HRESP;
      rsp_rdata_q <= (data_done && !d_write && !bus.HRESP) ? bus.HRDATA : '0;
    end
  end

  assign bus.HTRANS    = addr_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = a_q.addr;
  assign bus.HWRITE    = a_q.write;
  assign bus.HSIZE     = a_q.size;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = (d_valid && d_write) ? d_wdata : '0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_single_master.sv
// Bench for ahb_lite_single_master: directed vector table, hand-written
// multi-cycle sequences, and a random phase against a memory-based model.
module tb_ahb_lite_single_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic HCLK;
  logic HRESET;

  ahb_lite_single_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_lite_single_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .HPROT_VAL (4'b0011)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks;
  int errors;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] hrdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = '0;
    bus.cmd_wdata = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;
  endtask

  task automatic offer(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
  endtask

  // One isolated transfer: address phase, optional waits/ERROR, response, then quiet.
  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    offer(v.write, v.addr, v.size, v.wdata);
    #1;
    chk({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_pre_idle"}, 64'(bus.HTRANS), 64'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk({tag, "_htrans"}, 64'(bus.HTRANS), 64'd2);
    chk({tag, "_haddr"}, 64'(bus.HADDR), 64'(v.addr));
    chk({tag, "_hwrite"}, 64'(bus.HWRITE), 64'(v.write));
    chk({tag, "_hsize"}, 64'(bus.HSIZE), 64'(v.size));
    chk({tag, "_hburst"}, 64'(bus.HBURST), 64'd0);
    chk({tag, "_hprot"}, 64'(bus.HPROT), 64'd3);
    chk({tag, "_hmastlock"}, 64'(bus.HMASTLOCK), 64'd0);
    tick();
    for (int i = 0; i < v.waits; i++) begin
      bus.HREADY = 1'b0;
      bus.HRESP  = 1'b0;
      chk({tag, "_wait_hwdata"}, 64'(bus.HWDATA), v.write ? 64'(v.wdata) : 64'd0);
      chk({tag, "_wait_norsp"}, 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    if (v.err) begin
      bus.HREADY = 1'b0;
      bus.HRESP  = 1'b1;
      tick();
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b1;
      bus.HRDATA = v.hrdata;
      chk({tag, "_err2_idle"}, 64'(bus.HTRANS), 64'd0);
      tick();
    end else begin
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = v.hrdata;
      chk({tag, "_hwdata"}, 64'(bus.HWDATA), v.write ? 64'(v.wdata) : 64'd0);
      tick();
    end
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = $urandom();
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_rsp_error"}, 64'(bus.rsp_error), 64'(v.exp_err));
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(v.exp_rdata));
    tick();
    chk({tag, "_rsp_once"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  vec_t        vecs[7];
  logic [31:0] wd[3];
  logic [31:0] slave_mem[64];
  logic [31:0] model_mem[64];
  cmd_t        issue_q[$];
  rsp_t        rsp_q[$];

  initial begin
    cmd_t        cur;
    cmd_t        c;
    rsp_t        r;
    logic        pend;
    logic        accept;
    logic        addr_done;
    logic        data_done;
    logic        dp_valid;
    logic        dp_write;
    logic        dp_err;
    logic        dp_err2;
    int          dp_wait;
    logic [5:0]  dp_idx;
    logic [31:0] dp_wdata_exp;
    logic [31:0] tmp;
    logic        stray;

    checks = 0;
    errors = 0;

    //               write  addr          size  wdata         waits err hrdata        exp_err exp_rdata
    vecs[0] = '{1'b0, 32'h4000_0010, 3'd2, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0020, 3'd2, 32'h1234_5678, 2, 1'b0, 32'h7777_7777, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h8000_0004, 3'd1, 32'h0,         1, 1'b0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 32'h0000_0100, 3'd2, 32'h0,         0, 1'b1, 32'h55AA_55AA, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h0000_0200, 3'd2, 32'h0BAD_F00D, 1, 1'b1, 32'h1111_1111, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0003, 3'd0, 32'h0000_00FF, 0, 1'b0, 32'h2222_2222, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 3'd2, 32'h0,         3, 1'b0, 32'h0000_0001, 1'b0, 32'h0000_0001};

    // Reset state, checked while reset is held.
    HRESET = 1'b1;
    idle_inputs();
    #1;
    chk("rst_htrans", 64'(bus.HTRANS), 64'd0);
    chk("rst_haddr", 64'(bus.HADDR), 64'd0);
    chk("rst_hwrite", 64'(bus.HWRITE), 64'd0);
    chk("rst_hsize", 64'(bus.HSIZE), 64'd0);
    chk("rst_hwdata", 64'(bus.HWDATA), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_error", 64'(bus.rsp_error), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    tick();
    HRESET = 1'b0;
    tick();

    // Table-driven isolated transfers.
    for (int n = 0; n < 7; n++) begin
      run_vec(vecs[n], n);
      idle_inputs();
    end

    // Back-to-back writes: three NONSEQ in a row, HWDATA one cycle behind HADDR.
    wd[0] = 32'h0000_1111;
    wd[1] = 32'h2222_0000;
    wd[2] = 32'h3333_3333;
    for (int cy = 0; cy < 7; cy++) begin
      if (cy < 3) offer(1'b1, 32'(cy * 4), 3'd2, wd[cy]);
      else bus.cmd_valid = 1'b0;
      chk("b2b_htrans", 64'(bus.HTRANS), (cy >= 1 && cy <= 3) ? 64'd2 : 64'd0);
      if (cy >= 1 && cy <= 3) chk("b2b_haddr", 64'(bus.HADDR), 64'((cy - 1) * 4));
      if (cy >= 2 && cy <= 4) chk("b2b_hwdata", 64'(bus.HWDATA), 64'(wd[cy - 2]));
      chk("b2b_rsp_valid", 64'(bus.rsp_valid), (cy >= 3 && cy <= 5) ? 64'd1 : 64'd0);
      if (cy >= 3 && cy <= 5) chk("b2b_rsp_error", 64'(bus.rsp_error), 64'd0);
      tick();
    end
    idle_inputs();

    // Write with 3 wait states while the next write sits in the address phase.
    offer(1'b1, 32'h10, 3'd2, 32'hAAAA_0010);
    tick();
    offer(1'b1, 32'h14, 3'd2, 32'hBBBB_0014);
    #1;
    chk("ws_ready_pipe", 64'(bus.cmd_ready), 64'd1);
    chk("ws_haddr0", 64'(bus.HADDR), 64'h10);
    tick();
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h18, 3'd2, 32'hCCCC_0018);
      bus.HREADY = 1'b0;
      #1;
      chk("ws_ready_low", 64'(bus.cmd_ready), 64'd0);
      chk("ws_haddr_hold", 64'(bus.HADDR), 64'h14);
      chk("ws_htrans_hold", 64'(bus.HTRANS), 64'd2);
      chk("ws_hwdata_hold", 64'(bus.HWDATA), 64'hAAAA_0010);
      chk("ws_norsp", 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    bus.HREADY = 1'b1;
    #1;
    chk("ws_ready_release", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("ws_rsp0", 64'(bus.rsp_valid), 64'd1);
    chk("ws_rsp0_err", 64'(bus.rsp_error), 64'd0);
    chk("ws_haddr2", 64'(bus.HADDR), 64'h18);
    chk("ws_hwdata1", 64'(bus.HWDATA), 64'hBBBB_0014);
    tick();
    chk("ws_rsp1", 64'(bus.rsp_valid), 64'd1);
    chk("ws_hwdata2", 64'(bus.HWDATA), 64'hCCCC_0018);
    chk("ws_idle", 64'(bus.HTRANS), 64'd0);
    tick();
    chk("ws_rsp2", 64'(bus.rsp_valid), 64'd1);
    tick();
    chk("ws_rsp_end", 64'(bus.rsp_valid), 64'd0);
    idle_inputs();

    // ERROR on a read with a write pipelined behind it; the write is retried.
    offer(1'b0, 32'h100, 3'd2, 32'h0);
    tick();
    offer(1'b1, 32'h104, 3'd2, 32'hA5A5_0104);
    #1;
    chk("err_ready_pipe", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.HREADY    = 1'b0;
    bus.HRESP     = 1'b1;
    #1;
    chk("err1_ready", 64'(bus.cmd_ready), 64'd0);
    chk("err1_htrans", 64'(bus.HTRANS), 64'd2);
    chk("err1_haddr", 64'(bus.HADDR), 64'h104);
    tick();
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b1;
    bus.HRDATA = 32'h1234_5678;
    #1;
    chk("err2_htrans", 64'(bus.HTRANS), 64'd0);
    chk("err2_ready", 64'(bus.cmd_ready), 64'd0);
    chk("err2_norsp", 64'(bus.rsp_valid), 64'd0);
    tick();
    bus.HRESP = 1'b0;
    chk("err_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("err_rsp_error", 64'(bus.rsp_error), 64'd1);
    chk("err_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("retry_htrans", 64'(bus.HTRANS), 64'd2);
    chk("retry_haddr", 64'(bus.HADDR), 64'h104);
    chk("retry_hwrite", 64'(bus.HWRITE), 64'd1);
    tick();
    chk("retry_hwdata", 64'(bus.HWDATA), 64'hA5A5_0104);
    chk("retry_norsp", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("retry_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("retry_rsp_error", 64'(bus.rsp_error), 64'd0);
    tick();
    idle_inputs();

    // Idle with stray HRESP: no transfers and no responses.
    for (int i = 0; i < 5; i++) begin
      bus.HRESP  = 1'b1;
      bus.HREADY = i[0];
      tick();
      chk("idle_htrans", 64'(bus.HTRANS), 64'd0);
      chk("idle_norsp", 64'(bus.rsp_valid), 64'd0);
    end
    idle_inputs();
    tick();

    // Reset asserted mid-cycle during a write wait state.
    offer(1'b1, 32'h20, 3'd2, 32'hDDDD_0020);
    tick();
    offer(1'b1, 32'h24, 3'd2, 32'hDDDD_0024);
    tick();
    bus.cmd_valid = 1'b0;
    bus.HREADY    = 1'b0;
    tick();
    chk("mr_busy", 64'(bus.HTRANS), 64'd2);
    #2;
    HRESET = 1'b1;
    #1;
    chk("mr_htrans", 64'(bus.HTRANS), 64'd0);
    chk("mr_haddr", 64'(bus.HADDR), 64'd0);
    chk("mr_hwrite", 64'(bus.HWRITE), 64'd0);
    chk("mr_hwdata", 64'(bus.HWDATA), 64'd0);
    chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    HRESET     = 1'b0;
    bus.HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mr_after_ready", 64'(bus.cmd_ready), 64'd1);
      chk("mr_after_norsp", 64'(bus.rsp_valid), 64'd0);
      chk("mr_after_idle", 64'(bus.HTRANS), 64'd0);
      tick();
    end
    idle_inputs();

    // Random traffic against a memory model; ERROR for any address with bits [7:5] all set.
    for (int i = 0; i < 64; i++) begin
      slave_mem[i] = $urandom();
      model_mem[i] = slave_mem[i];
    end
    pend     = 1'b0;
    dp_valid = 1'b0;
    dp_write = 1'b0;
    dp_err   = 1'b0;
    dp_err2  = 1'b0;
    dp_wait  = 0;
    dp_idx   = '0;
    dp_wdata_exp = '0;
    cur      = '{1'b0, 32'h0, 3'd0, 32'h0};
    for (int cy = 0; cy < 2200; cy++) begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_rsp_unexpected: got rsp_valid=1 expected no response at %0t", $time);
        end else begin
          r = rsp_q.pop_front();
          chk("rnd_rsp_error", 64'(bus.rsp_error), 64'(r.err));
          chk("rnd_rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
        end
      end

      stray = ($urandom_range(0, 7) == 0);
      bus.HRDATA = $urandom();
      if (!dp_valid) begin
        bus.HREADY = 1'b1;
        bus.HRESP  = stray;
      end else if (dp_wait > 0) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b0;
      end else if (dp_err && !dp_err2) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
      end else if (dp_err) begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b1;
      end else begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        if (!dp_write) bus.HRDATA = slave_mem[dp_idx];
      end

      if (!pend && cy < 2000 && $urandom_range(0, 99) < 70) begin
        pend      = 1'b1;
        tmp       = $urandom();
        cur.write = 1'($urandom_range(0, 1));
        cur.addr  = {tmp[31:8], 6'($urandom_range(0, 63)), 2'b00};
        cur.size  = 3'($urandom_range(0, 2));
        cur.wdata = $urandom();
      end
      bus.cmd_valid = pend;
      bus.cmd_write = cur.write;
      bus.cmd_addr  = cur.addr;
      bus.cmd_size  = cur.size;
      bus.cmd_wdata = cur.wdata;
      #1;

      accept    = pend && bus.cmd_ready;
      addr_done = (bus.HTRANS == 2'b10) && bus.HREADY;
      data_done = dp_valid && bus.HREADY;

      if (dp_valid) begin
        if (data_done) begin
          if (dp_write && !dp_err) begin
            chk("rnd_hwdata", 64'(bus.HWDATA), 64'(dp_wdata_exp));
            slave_mem[dp_idx] = bus.HWDATA;
          end
          dp_valid = 1'b0;
        end else if (dp_wait > 0) begin
          dp_wait--;
        end else if (dp_err) begin
          dp_err2 = 1'b1;
        end
      end

      if (addr_done) begin
        if (issue_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_issue_unexpected: got NONSEQ at 0x%0h expected no transfer at %0t", bus.HADDR, $time);
        end else begin
          c = issue_q.pop_front();
          chk("rnd_haddr", 64'(bus.HADDR), 64'(c.addr));
          chk("rnd_hwrite", 64'(bus.HWRITE), 64'(c.write));
          chk("rnd_hsize", 64'(bus.HSIZE), 64'(c.size));
          dp_wdata_exp = c.wdata;
        end
        dp_valid = 1'b1;
        dp_write = bus.HWRITE;
        dp_idx   = bus.HADDR[7:2];
        dp_err   = (bus.HADDR[7:5] == 3'b111);
        dp_err2  = 1'b0;
        dp_wait  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end

      if (accept) begin
        issue_q.push_back(cur);
        r.err   = (cur.addr[7:5] == 3'b111);
        r.rdata = '0;
        if (!r.err) begin
          if (cur.write) model_mem[cur.addr[7:2]] = cur.wdata;
          else r.rdata = model_mem[cur.addr[7:2]];
        end
        rsp_q.push_back(r);
        pend = 1'b0;
      end
      tick();
    end
    chk("rnd_drain_rsp", 64'(rsp_q.size()), 64'd0);
    chk("rnd_drain_issue", 64'(issue_q.size()), 64'd0);
    chk("rnd_drain_pend", 64'(pend), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
